// File: rtl/gfx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gfx_pkg: shared pixel-pipeline constants, types and helpers           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package gfx_pkg;

  localparam int PIXEL_W = 12;
  localparam logic [PIXEL_W-1:0] KEY_COLOR_DEFAULT = 12'h0F0;
  localparam logic [9:0] FRAME_END_V = 10'd480;

  localparam int LAYER_BG  = 0;
  localparam int LAYER_TER = 1;
  localparam int LAYER_P2  = 2;
  localparam int LAYER_P1  = 3;
  localparam int NUM_LAYERS = 4;

  // Control bits that travel through the ROM-latency delay line together.
  typedef struct packed {
    logic frame_end;
    logic p2_en;
    logic p1_en;
    logic ter_en;
    logic valid;
  } ctrl_t;

  function automatic logic is_opaque(
    input logic               en,
    input logic [PIXEL_W-1:0] pix,
    input logic [PIXEL_W-1:0] key
  );
    return en && (pix != key);
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | delay_line: DEPTH-stage register chain, cleared by synchronous reset  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= i_d;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= {r_pipe[DEPTH-2:0], i_d};
      end
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pixel_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pixel_compositor: layer priority mux with chroma key, plus per-frame  |
// | pixel-exact collision flags.                              Rev 1.0     |
// +----------------------------------------------------------------------+
module pixel_compositor
  import gfx_pkg::*;
#(
  parameter int                 ROM_LATENCY = 1,
  parameter logic [PIXEL_W-1:0] KEY_COLOR   = KEY_COLOR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [9:0]         vga_h,
  input  logic [9:0]         vga_v,
  input  logic [PIXEL_W-1:0] bg_data,
  input  logic               ter_en,
  input  logic [PIXEL_W-1:0] ter_data,
  input  logic               p1_en,
  input  logic [PIXEL_W-1:0] p1_data,
  input  logic               p2_en,
  input  logic [PIXEL_W-1:0] p2_data,
  output logic [PIXEL_W-1:0] rgb,
  output logic               collision_with_player1,
  output logic               collision_with_player2,
  output logic               collision_players,
  output logic               frame_done
);

  ctrl_t                 w_ctrl_in;
  ctrl_t                 w_ctrl_d;
  logic [NUM_LAYERS-1:0] w_opaque;
  logic [PIXEL_W-1:0]    w_pix_sel;
  logic                  w_hit_p1t;
  logic                  w_hit_p2t;
  logic                  w_hit_pp;
  logic                  r_acc_p1t;
  logic                  r_acc_p2t;
  logic                  r_acc_pp;

  assign w_ctrl_in.frame_end = (vga_h == 10'd0) && (vga_v == FRAME_END_V);
  assign w_ctrl_in.p2_en     = p2_en;
  assign w_ctrl_in.p1_en     = p1_en;
  assign w_ctrl_in.ter_en    = ter_en;
  assign w_ctrl_in.valid     = valid;

  delay_line #(
    .WIDTH ($bits(ctrl_t)),
    .DEPTH (ROM_LATENCY)
  ) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_ctrl_in),
    .o_q (w_ctrl_d)
  );

  assign w_opaque[LAYER_BG]  = w_ctrl_d.valid;
  assign w_opaque[LAYER_TER] = is_opaque(w_ctrl_d.ter_en, ter_data, KEY_COLOR);
  assign w_opaque[LAYER_P2]  = is_opaque(w_ctrl_d.p2_en,  p2_data,  KEY_COLOR);
  assign w_opaque[LAYER_P1]  = is_opaque(w_ctrl_d.p1_en,  p1_data,  KEY_COLOR);

  always_comb begin
    w_pix_sel = '0;
    if (w_ctrl_d.valid) begin
      if (w_opaque[LAYER_P1]) begin
        w_pix_sel = p1_data;
      end else if (w_opaque[LAYER_P2]) begin
        w_pix_sel = p2_data;
      end else if (w_opaque[LAYER_TER]) begin
        w_pix_sel = ter_data;
      end else begin
        w_pix_sel = bg_data;
      end
    end
  end

  assign w_hit_p1t = w_opaque[LAYER_P1] && w_opaque[LAYER_TER];
  assign w_hit_p2t = w_opaque[LAYER_P2] && w_opaque[LAYER_TER];
  assign w_hit_pp  = w_opaque[LAYER_P1] && w_opaque[LAYER_P2];

  // Frame end takes precedence, so a coincident set is dropped with the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb                    <= '0;
      frame_done             <= 1'b0;
      collision_with_player1 <= 1'b0;
      collision_with_player2 <= 1'b0;
      collision_players      <= 1'b0;
      r_acc_p1t              <= 1'b0;
      r_acc_p2t              <= 1'b0;
      r_acc_pp               <= 1'b0;
    end else begin
      rgb        <= w_pix_sel;
      frame_done <= w_ctrl_d.frame_end;
      if (w_ctrl_d.frame_end) begin
        collision_with_player1 <= r_acc_p1t;
        collision_with_player2 <= r_acc_p2t;
        collision_players      <= r_acc_pp;
        r_acc_p1t              <= 1'b0;
        r_acc_p2t              <= 1'b0;
        r_acc_pp               <= 1'b0;
      end else if (w_ctrl_d.valid) begin
        r_acc_p1t <= r_acc_p1t | w_hit_p1t;
        r_acc_p2t <= r_acc_p2t | w_hit_p2t;
        r_acc_pp  <= r_acc_pp  | w_hit_pp;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pixel_compositor: two instances (latency 1 / latency 3 with a     |
// | different key) against a history-based reference model.   Rev 1.0   |
// +----------------------------------------------------------------------+
module tb_pixel_compositor;

  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, valid, ter_en, p1_en, p2_en;
  logic [9:0]  vga_h, vga_v;
  logic [11:0] bg_data, ter_data, p1_data, p2_data;
  logic [11:0] rgb_a, rgb_b;
  logic        c1_a, c2_a, cp_a, fd_a;
  logic        c1_b, c2_b, cp_b, fd_b;

  pixel_compositor #(.ROM_LATENCY(1), .KEY_COLOR(12'h0F0)) u_dut_a (
    .clk(clk), .rst(rst), .valid(valid), .vga_h(vga_h), .vga_v(vga_v),
    .bg_data(bg_data), .ter_en(ter_en), .ter_data(ter_data),
    .p1_en(p1_en), .p1_data(p1_data), .p2_en(p2_en), .p2_data(p2_data),
    .rgb(rgb_a), .collision_with_player1(c1_a), .collision_with_player2(c2_a),
    .collision_players(cp_a), .frame_done(fd_a)
  );

  pixel_compositor #(.ROM_LATENCY(3), .KEY_COLOR(12'h123)) u_dut_b (
    .clk(clk), .rst(rst), .valid(valid), .vga_h(vga_h), .vga_v(vga_v),
    .bg_data(bg_data), .ter_en(ter_en), .ter_data(ter_data),
    .p1_en(p1_en), .p1_data(p1_data), .p2_en(p2_en), .p2_data(p2_data),
    .rgb(rgb_b), .collision_with_player1(c1_b), .collision_with_player2(c2_b),
    .collision_players(cp_b), .frame_done(fd_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Input history, one entry per clock cycle.
  bit          h_rst[MAXC], h_val[MAXC], h_fe[MAXC], h_te[MAXC], h_e1[MAXC], h_e2[MAXC];
  logic [11:0] h_bg[MAXC], h_ter[MAXC], h_p1[MAXC], h_p2[MAXC];

  // Reference state per instance: frame overlap sets and expected outputs.
  bit          m_acc[2][3];
  bit          e_col[2][3];
  bit          e_fd[2];
  logic [11:0] e_rgb[2];

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs after the clock edge that samples cycle `cyc`.
  task automatic model_step(input int i, input int lat, input logic [11:0] key);
    int  k;
    bit  ok, v, fe, o1, o2, ot;
    k = cyc;
    if (!h_rst[k]) begin
      e_rgb[i] = 12'h000;
      e_fd[i]  = 1'b0;
      for (int j = 0; j < 3; j++) begin
        e_col[i][j] = 1'b0;
        m_acc[i][j] = 1'b0;
      end
      return;
    end
    ok = (k >= lat);
    for (int j = k - lat; j < k; j++)
      if (j >= 0 && !h_rst[j]) ok = 1'b0;
    v = 0; fe = 0; o1 = 0; o2 = 0; ot = 0;
    if (ok) begin
      v  = h_val[k-lat];
      fe = h_fe[k-lat];
      o1 = h_e1[k-lat] && (h_p1[k] != key);
      o2 = h_e2[k-lat] && (h_p2[k] != key);
      ot = h_te[k-lat] && (h_ter[k] != key);
    end
    if (!v)      e_rgb[i] = 12'h000;
    else if (o1) e_rgb[i] = h_p1[k];
    else if (o2) e_rgb[i] = h_p2[k];
    else if (ot) e_rgb[i] = h_ter[k];
    else         e_rgb[i] = h_bg[k];
    e_fd[i] = fe;
    if (fe) begin
      for (int j = 0; j < 3; j++) begin
        e_col[i][j] = m_acc[i][j];
        m_acc[i][j] = 1'b0;
      end
    end else if (v) begin
      m_acc[i][0] = m_acc[i][0] | (o1 && ot);
      m_acc[i][1] = m_acc[i][1] | (o2 && ot);
      m_acc[i][2] = m_acc[i][2] | (o1 && o2);
    end
  endtask

  task automatic tick();
    h_rst[cyc] = rst;   h_val[cyc] = valid;
    h_fe[cyc]  = (vga_h == 10'd0) && (vga_v == 10'd480);
    h_te[cyc]  = ter_en; h_e1[cyc] = p1_en; h_e2[cyc] = p2_en;
    h_bg[cyc]  = bg_data; h_ter[cyc] = ter_data; h_p1[cyc] = p1_data; h_p2[cyc] = p2_data;
    model_step(0, 1, 12'h0F0);
    model_step(1, 3, 12'h123);
    @(negedge clk);
    chk("rgb_a", rgb_a, e_rgb[0]);
    chk("col_p1_a", {11'b0, c1_a}, {11'b0, e_col[0][0]});
    chk("col_p2_a", {11'b0, c2_a}, {11'b0, e_col[0][1]});
    chk("col_pp_a", {11'b0, cp_a}, {11'b0, e_col[0][2]});
    chk("fdone_a",  {11'b0, fd_a}, {11'b0, e_fd[0]});
    chk("rgb_b", rgb_b, e_rgb[1]);
    chk("col_p1_b", {11'b0, c1_b}, {11'b0, e_col[1][0]});
    chk("col_p2_b", {11'b0, c2_b}, {11'b0, e_col[1][1]});
    chk("col_pp_b", {11'b0, cp_b}, {11'b0, e_col[1][2]});
    chk("fdone_b",  {11'b0, fd_b}, {11'b0, e_fd[1]});
    cyc++;
  endtask

  task automatic set_px(input bit v, input int h, input int vv, input logic [11:0] bg,
                        input bit te, input logic [11:0] t, input bit e1, input logic [11:0] d1,
                        input bit e2, input logic [11:0] d2);
    rst = 1'b1; valid = v; vga_h = h[9:0]; vga_v = vv[9:0]; bg_data = bg;
    ter_en = te; ter_data = t; p1_en = e1; p1_data = d1; p2_en = e2; p2_data = d2;
  endtask

  task automatic frame_end();
    set_px(0, 0, 480, 12'h000, 0, 12'h000, 0, 12'h000, 0, 12'h000);
    tick();
    repeat (4) begin
      set_px(0, 10, 490, 12'h000, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      tick();
    end
  endtask

  function automatic logic [11:0] pick_pix();
    case ($urandom_range(0, 4))
      0:       return 12'h0F0;
      1:       return 12'h123;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    set_px(0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, 0, 12'h000);
    rst = 1'b0;
    repeat (4) tick();
    chk("reset_rgb", rgb_a, 12'h000);

    // Transparency (latency 1, key 0F0)
    set_px(1, 100, 100, 12'h00F, 1, 12'hA52, 1, 12'h0F0, 0, 12'h000);
    tick(); tick();
    chk("transp_ter", rgb_a, 12'hA52);
    set_px(1, 102, 100, 12'h00F, 0, 12'hA52, 1, 12'h0F0, 0, 12'h000);
    tick(); tick();
    chk("transp_bg", rgb_a, 12'h00F);

    // Priority (latency 3, key 123)
    set_px(1, 200, 100, 12'h00F, 1, 12'h00F, 1, 12'hF00, 1, 12'h0F0);
    repeat (4) tick();
    chk("prio_p1", rgb_b, 12'hF00);
    set_px(1, 210, 100, 12'h00F, 1, 12'h00F, 0, 12'hF00, 1, 12'h0F0);
    repeat (4) tick();
    chk("prio_p2", rgb_b, 12'h0F0);
    chk("prio_keyed_p2", rgb_a, 12'h00F);

    frame_end();
    frame_end();
    chk("flushed_p1", {11'b0, c1_a}, 12'h000);

    // Blanking: nothing drawn, nothing accumulated
    set_px(0, 700, 100, 12'h00F, 1, 12'hA52, 1, 12'hF00, 1, 12'h00A);
    repeat (4) tick();
    chk("blank_rgb_a", rgb_a, 12'h000);
    chk("blank_rgb_b", rgb_b, 12'h000);
    frame_end();
    chk("blank_col_pp", {11'b0, cp_a}, 12'h000);

    // Collision frame
    set_px(1, 300, 200, 12'h00F, 1, 12'hA52, 1, 12'hF00, 0, 12'h000);
    tick();
    repeat (5) begin
      set_px(1, 301, 200, 12'h00F, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      tick();
    end
    chk("col_before_fd", {11'b0, c1_a}, 12'h000);
    frame_end();
    chk("col_after_fd_a", {11'b0, c1_a}, 12'h001);
    chk("col_after_fd_b", {11'b0, c1_b}, 12'h001);
    repeat (5) begin
      set_px(1, 50, 60, 12'h00F, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      tick();
    end
    chk("col_held", {11'b0, c1_a}, 12'h001);
    frame_end();
    chk("col_cleared", {11'b0, c1_a}, 12'h000);

    // Reset mid-frame after an overlap
    set_px(1, 399, 200, 12'h00F, 1, 12'hA52, 1, 12'hF00, 1, 12'h00A);
    tick();
    set_px(1, 400, 200, 12'h00F, 1, 12'hA52, 1, 12'hF00, 1, 12'h00A);
    rst = 1'b0;
    tick();
    chk("rst_rgb", rgb_a, 12'h000);
    chk("rst_fd", {11'b0, fd_a}, 12'h000);
    repeat (3) begin
      set_px(1, 401, 200, 12'h00F, 0, 12'h000, 0, 12'h000, 0, 12'h000);
      tick();
    end
    frame_end();
    chk("rst_col_a", {11'b0, c1_a}, 12'h000);
    chk("rst_col_b", {11'b0, c1_b}, 12'h000);

    // Randomized frames, markers, blanking and occasional resets
    for (int n = 0; n < 2500 && cyc < MAXC - 8; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        set_px($urandom_range(0, 9) == 0, 0, 480, pick_pix(),
               1'($urandom), pick_pix(), 1'($urandom), pick_pix(), 1'($urandom), pick_pix());
      end else begin
        set_px($urandom_range(0, 9) != 0, $urandom_range(0, 639), $urandom_range(0, 479),
               pick_pix(), 1'($urandom), pick_pix(), 1'($urandom), pick_pix(),
               1'($urandom), pick_pix());
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_compositor.md
# pixel_compositor

Downstream of the per-object renderers (terrain, player sprites): merges their enables and ROM pixel data into the final 12-bit VGA colour with fixed layer priority and chroma-key transparency. It also derives per-frame pixel-exact collision flags from overlapping opaque pixels. Its output drives the VGA RGB pins directly; its collision flags feed the game-logic FSM.

## Interface

Parameters:
- ROM_LATENCY, 1: cycles from a renderer's addr/en to valid ROM data (1..4).
- KEY_COLOR, 12'h0F0: transparent colour; a layer pixel equal to this is not drawn.

Ports:
- clk  input  1  pixel clock (25 MHz); all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- valid  input  1  active-video flag from the VGA controller, aligned with vga_h/vga_v.
- vga_h  input  10  current horizontal pixel, 0..799.
- vga_v  input  10  current vertical line, 0..524.
- bg_data  input  12  background ROM pixel (always-enabled layer).
- ter_en  input  1  terrain renderer enable.
- ter_data  input  12  terrain ROM pixel.
- p1_en  input  1  player1 renderer enable.
- p1_data  input  12  player1 ROM pixel.
- p2_en  input  1  player2 renderer enable.
- p2_data  input  12  player2 ROM pixel.
- rgb  output  12  {R[3:0],G[3:0],B[3:0]} to the VGA pins.
- collision_with_player1  output  1  player1 overlapped terrain during the last frame.
- collision_with_player2  output  1  player2 overlapped terrain during the last frame.
- collision_players  output  1  player1 overlapped player2 during the last frame.
- frame_done  output  1  one-cycle pulse when the collision flags update.

## Operation

- Alignment:
  - valid, ter_en, p1_en and p2_en are delayed ROM_LATENCY cycles so they line up with the *_data inputs.
  - The frame-end marker (vga_h==0 && vga_v==480) is delayed the same amount.
- Opacity, per aligned cycle:
  - layer X is opaque iff en_d(X)==1 and data(X)!=KEY_COLOR;
  - background is opaque whenever valid_d==1.
- Priority: player1 > player2 > terrain > background. The selected pixel is registered into rgb.
- valid_d==0: rgb is registered as 12'h000 regardless of enables.
- Collision accumulators (acc_p1t, acc_p2t, acc_pp):
  - sticky set when both relevant layers are opaque and valid_d==1;
  - while valid_d==0 they hold.
- Frame end (aligned marker high):
  - the collision outputs load the accumulators;
  - the accumulators clear;
  - frame_done is 1 on that cycle's registered output.
  - Frame end is always in vertical blanking, so no set can coincide with the clear. If one ever does, the clear wins and the set is dropped.
- Reset (rst==0, any cycle, including mid-frame):
  - delay lines, accumulators, rgb, collision outputs and frame_done all go to 0;
  - the first frame after reset reports collisions only from the pixels seen after reset.
- No arithmetic beyond 12-bit equality compares and the 10-bit frame-end compare.

## Timing

- Latency:
  - ROM_LATENCY+1 cycles from valid/vga_h/vga_v/en to rgb;
  - 1 cycle from *_data to rgb.
  - The VGA controller must delay hsync/vsync by ROM_LATENCY+1 to match.
- Collision flags change only on the frame_done cycle and are stable for the whole following frame, giving game logic a full frame to sample.
- frame_done: exactly one cycle wide, once per 800*525 cycles, ROM_LATENCY+1 cycles after (vga_h,vga_v)=(0,480).
- Reset values of all outputs: 0.

## Structure

- Shared package gfx_pkg:
  - PIXEL_W=12;
  - KEY_COLOR default;
  - FRAME_END_V=480;
  - layer index constants (LAYER_BG=0, LAYER_TER=1, LAYER_P2=2, LAYER_P1=3).
- Sub-module delay_line, parameterised (WIDTH, DEPTH), same clk/rst.
  - One instance carries {frame_end, p2_en, p1_en, ter_en, valid}.
  - Reusable by the VGA controller for the sync delay.
- Remaining logic (priority mux, accumulators, output registers) stays inline; about 150–200 lines total.

## Test plan

- Transparency:
  - stimulus: ROM_LATENCY=1, valid=1, p1_en=1, p1_data=KEY_COLOR, ter_en=1, ter_data=12'hA52, bg_data=12'h00F;
  - required: rgb=12'hA52 two cycles later; with ter_en=0, rgb=12'h00F.
- Priority:
  - stimulus: all layers enabled and opaque (p1=12'hF00, p2=12'h0F0 with KEY_COLOR changed to 12'h123, ter=12'h00F);
  - required: rgb=12'hF00; dropping p1_en gives 12'h0F0.
- Blanking:
  - stimulus: valid=0 with all layers enabled and opaque;
  - required: rgb=12'h000; no accumulator set.
- Collision frame:
  - stimulus: one cycle with p1 and terrain both opaque mid-frame;
  - required: collision_with_player1 stays 0 until frame_done, then reads 1 for the whole next frame; a clean next frame returns it to 0 at the following frame_done.
- Reset mid-frame:
  - stimulus: assert rst=0 for 1 cycle at (400,200) after an overlap;
  - required: all outputs 0 next cycle, and the overlap is not reported at the next frame_done.
- Latency sweep:
  - stimulus: ROM_LATENCY=3;
  - required: rgb and frame_done arrive 4 cycles after the inputs, and frame_done is one cycle wide.
